// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, branch-type encoding and the
// memory/writeback control bundle carried between pipeline registers.
package pipeline_pkg;

  localparam int unsigned XLEN_DEFAULT       = 64;
  localparam int unsigned REG_ADDR_W_DEFAULT = 5;

  localparam logic [1:0] BR_BEQ = 2'b00;
  localparam logic [1:0] BR_BNE = 2'b01;
  localparam logic [1:0] BR_BLT = 2'b10;
  localparam logic [1:0] BR_BGE = 2'b11;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } mem_wb_ctrl_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bundle: execute-stage inputs, hazard controls and the
// registered memory-stage / forwarding outputs.
interface ex_mem_stage_if import pipeline_pkg::*; #(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT
);
  logic                  in_valid;
  logic                  stall;
  logic                  flush;
  logic [XLEN-1:0]       alu_result;
  logic                  alu_zero;
  logic [XLEN-1:0]       rs2_data;
  logic [XLEN-1:0]       pc_in;
  logic [XLEN-1:0]       imm_in;
  logic [REG_ADDR_W-1:0] rd_in;
  logic                  reg_write_in;
  logic                  mem_read_in;
  logic                  mem_write_in;
  logic                  mem_to_reg_in;
  logic                  branch_in;
  logic [1:0]            branch_type_in;

  logic                  valid_out;
  logic [XLEN-1:0]       result_out;
  logic [XLEN-1:0]       store_data_out;
  logic [REG_ADDR_W-1:0] rd_out;
  logic                  reg_write_out;
  logic                  mem_read_out;
  logic                  mem_write_out;
  logic                  mem_to_reg_out;
  logic                  branch_taken;
  logic [XLEN-1:0]       branch_target;
  logic                  fwd_en;
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic [XLEN-1:0]       fwd_data;

  modport master (
    output in_valid, stall, flush, alu_result, alu_zero, rs2_data, pc_in, imm_in, rd_in,
           reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in, branch_type_in,
    input  valid_out, result_out, store_data_out, rd_out, reg_write_out, mem_read_out,
           mem_write_out, mem_to_reg_out, branch_taken, branch_target, fwd_en, fwd_rd, fwd_data
  );

  modport slave (
    input  in_valid, stall, flush, alu_result, alu_zero, rs2_data, pc_in, imm_in, rd_in,
           reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in, branch_type_in,
    output valid_out, result_out, store_data_out, rd_out, reg_write_out, mem_read_out,
           mem_write_out, mem_to_reg_out, branch_taken, branch_target, fwd_en, fwd_rd, fwd_data
  );

endinterface

// File: rtl/branch_resolve.sv
// Combinational branch decision from the ALU zero flag and PC-relative target.
module branch_resolve import pipeline_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]      branch_type_i,
  input  logic            alu_zero_i,
  input  logic            branch_i,
  input  logic            in_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o
);

  logic cond;

  // BLT/BGE use the ALU compare op, which yields zero when a < b.
  always_comb begin
    cond = 1'b0;
    unique case (branch_type_i)
      BR_BEQ:  cond = alu_zero_i;
      BR_BNE:  cond = ~alu_zero_i;
      BR_BLT:  cond = alu_zero_i;
      BR_BGE:  cond = ~alu_zero_i;
      default: cond = 1'b0;
    endcase
  end

  assign taken_o  = in_valid_i & branch_i & cond;
  assign target_o = pc_i + (imm_i << 1);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution and a registered
// forwarding port. Priority per edge: reset > flush > stall > load.
module ex_mem_stage import pipeline_pkg::*; #(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  ex_mem_stage_if.slave bus
);

  logic                  valid_d, valid_q;
  mem_wb_ctrl_t          ctrl_d, ctrl_q;
  logic [XLEN-1:0]       result_d, result_q;
  logic [XLEN-1:0]       store_d, store_q;
  logic [REG_ADDR_W-1:0] rd_d, rd_q;
  logic                  taken_d, taken_q;
  logic [XLEN-1:0]       target_d, target_q;

  logic                  br_taken;
  logic [XLEN-1:0]       br_target;

  branch_resolve #(
    .XLEN(XLEN)
  ) u_branch_resolve (
    .branch_type_i(bus.branch_type_in),
    .alu_zero_i   (bus.alu_zero),
    .branch_i     (bus.branch_in),
    .in_valid_i   (bus.in_valid),
    .pc_i         (bus.pc_in),
    .imm_i        (bus.imm_in),
    .taken_o      (br_taken),
    .target_o     (br_target)
  );

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    store_d  = store_q;
    rd_d     = rd_q;
    taken_d  = taken_q;
    target_d = target_q;
    if (bus.flush) begin
      valid_d  = 1'b0;
      ctrl_d   = '0;
      result_d = '0;
      store_d  = '0;
      rd_d     = '0;
      taken_d  = 1'b0;
      target_d = '0;
    end else if (!bus.stall) begin
      // A bubble (in_valid=0) still captures data fields; only control is gated.
      valid_d           = bus.in_valid;
      ctrl_d.reg_write  = bus.reg_write_in & bus.in_valid;
      ctrl_d.mem_read   = bus.mem_read_in & bus.in_valid;
      ctrl_d.mem_write  = bus.mem_write_in & bus.in_valid;
      ctrl_d.mem_to_reg = bus.mem_to_reg_in & bus.in_valid;
      result_d          = bus.alu_result;
      store_d           = bus.rs2_data;
      rd_d              = bus.rd_in;
      taken_d           = br_taken;
      target_d          = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      result_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign bus.valid_out      = valid_q;
  assign bus.result_out     = result_q;
  assign bus.store_data_out = store_q;
  assign bus.rd_out         = rd_q;
  assign bus.reg_write_out  = ctrl_q.reg_write;
  assign bus.mem_read_out   = ctrl_q.mem_read;
  assign bus.mem_write_out  = ctrl_q.mem_write;
  assign bus.mem_to_reg_out = ctrl_q.mem_to_reg;
  assign bus.branch_taken   = taken_q;
  assign bus.branch_target  = target_q;

  // Loads never forward from here; the hazard unit stalls for them instead.
  assign bus.fwd_en   = valid_q & ctrl_q.reg_write & (rd_q != '0) & ~ctrl_q.mem_read;
  assign bus.fwd_rd   = rd_q;
  assign bus.fwd_data = result_q;

endmodule
